operand_entry: RTL and testbench

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry_pkg.sv | 14 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/operand_entry.sv | 108 ++++++++++
 tb/tb_operand_entry.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry block: operand width and the
// load-tracking FSM encoding.
package operand_entry_pkg;

    localparam int OPERAND_W = 3;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2,
        FULL   = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, debounce counter and rising-edge press detector for
// one raw push button; press is a single-cycle pulse per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The counter counts consecutive samples disagreeing with the accepted
    // level; the edge that would bring it to DEBOUNCE_CYCLES flips the level
    // and clears it instead, so it can never run past its terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/operand_entry.sv
// Captures two 3-bit adder operands from switches on debounced button presses
// and tracks which operands have been loaded since the last clear.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] sw,
    input  logic                 btn_a,
    input  logic                 btn_b,
    input  logic                 btn_clr,
    output logic [OPERAND_W-1:0] in1,
    output logic [OPERAND_W-1:0] in2,
    output logic                 a_valid,
    output logic                 b_valid,
    output logic                 ready
);

    logic [OPERAND_W-1:0] sw_s1;
    logic [OPERAND_W-1:0] sw_s2;
    logic                 press_a;
    logic                 press_b;
    logic                 press_clr;

    state_t               state_q;
    state_t               state_d;
    logic [OPERAND_W-1:0] opa_q;
    logic [OPERAND_W-1:0] opa_d;
    logic [OPERAND_W-1:0] opb_q;
    logic [OPERAND_W-1:0] opb_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_a),
        .press (press_a)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_b),
        .press (press_b)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clr),
        .press (press_clr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            state_q <= EMPTY;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // Clear beats loads; a re-press of an already loaded operand just
    // overwrites its value without disturbing the state.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        if (press_clr) begin
            state_d = EMPTY;
            opa_d   = '0;
            opb_d   = '0;
        end else if (press_a && press_b) begin
            state_d = FULL;
            opa_d   = sw_s2;
            opb_d   = sw_s2;
        end else if (press_a) begin
            opa_d = sw_s2;
            case (state_q)
                EMPTY:   state_d = HAVE_A;
                HAVE_B:  state_d = FULL;
                default: state_d = state_q;
            endcase
        end else if (press_b) begin
            opb_d = sw_s2;
            case (state_q)
                EMPTY:   state_d = HAVE_B;
                HAVE_A:  state_d = FULL;
                default: state_d = state_q;
            endcase
        end
    end

    assign in1     = opa_q;
    assign in2     = opb_q;
    assign a_valid = (state_q == HAVE_A) || (state_q == FULL);
    assign b_valid = (state_q == HAVE_B) || (state_q == FULL);
    assign ready   = (state_q == FULL);

endmodule

// File: tb/tb_operand_entry.sv
// Testbench for operand_entry: directed scenarios plus randomized button
// traffic, checked every cycle against a window-based behavioural model.
module tb_operand_entry;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw;
    logic       btn_a;
    logic       btn_b;
    logic       btn_clr;
    logic [2:0] in1;
    logic [2:0] in2;
    logic       a_valid;
    logic       b_valid;
    logic       ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state: operand values plus independent loaded flags, and per
    // button the last N synchronised samples and the accepted level.
    logic [2:0]   m_in1 = '0;
    logic [2:0]   m_in2 = '0;
    logic         m_a = 1'b0;
    logic         m_b = 1'b0;
    logic [N-1:0] hist [3];
    logic [2:0]   lvl = '0;
    logic [2:0]   ev = '0;
    logic [2:0]   btn_s1 = '0;
    logic [2:0]   btn_s2 = '0;
    logic [2:0]   sw_s1 = '0;
    logic [2:0]   sw_s2 = '0;
    bit           model_ok = 1'b0;

    operand_entry #(.DEBOUNCE_CYCLES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .btn_a   (btn_a),
        .btn_b   (btn_b),
        .btn_clr (btn_clr),
        .in1     (in1),
        .in2     (in2),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Inputs change just after a falling edge and are held for the given
    // number of rising edges; returns just after the last falling edge.
    task automatic applyStimulus(input logic r, input logic [2:0] s, input logic a,
                                 input logic b, input logic c, input int cycles);
        rst     = r;
        sw      = s;
        btn_a   = a;
        btn_b   = b;
        btn_clr = c;
        repeat (cycles) @(negedge clk);
    endtask

    // A level is accepted once N consecutive synchronised samples disagree
    // with it; presses act on the edge after acceptance using the sw value
    // that was synchronised at that moment.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_in1 = '0; m_in2 = '0; m_a = 1'b0; m_b = 1'b0;
                for (int i = 0; i < 3; i++) hist[i] = '0;
                lvl = '0; ev = '0;
                btn_s1 = '0; btn_s2 = '0; sw_s1 = '0; sw_s2 = '0;
                model_ok = 1'b1;
            end else begin
                if (ev[2]) begin
                    m_in1 = '0; m_in2 = '0; m_a = 1'b0; m_b = 1'b0;
                end else begin
                    if (ev[0]) begin m_in1 = sw_s2; m_a = 1'b1; end
                    if (ev[1]) begin m_in2 = sw_s2; m_b = 1'b1; end
                end
                for (int i = 0; i < 3; i++) begin
                    hist[i] = {hist[i][N-2:0], btn_s2[i]};
                    ev[i] = 1'b0;
                    if (hist[i] == {N{~lvl[i]}}) begin
                        lvl[i] = ~lvl[i];
                        ev[i]  = lvl[i];
                    end
                end
                btn_s2 = btn_s1;
                btn_s1 = {btn_clr, btn_b, btn_a};
                sw_s2  = sw_s1;
                sw_s1  = sw;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                checkOutput("model in1", in1, m_in1);
                checkOutput("model in2", in2, m_in2);
                checkOutput("model a_valid", a_valid, m_a);
                checkOutput("model b_valid", b_valid, m_b);
                checkOutput("model ready", ready, m_a && m_b);
            end
        end
    end

    initial begin
        rst = 1'b1; sw = '0; btn_a = 1'b0; btn_b = 1'b0; btn_clr = 1'b0;

        applyStimulus(1, 3'd0, 0, 0, 0, 2);
        checkOutput("reset in1", in1, 0);
        checkOutput("reset in2", in2, 0);
        checkOutput("reset a_valid", a_valid, 0);
        checkOutput("reset b_valid", b_valid, 0);
        checkOutput("reset ready", ready, 0);

        // Load A: nothing at edge 6, in1=5 at edge 7, held press gives one event.
        applyStimulus(0, 3'd5, 0, 0, 0, 3);
        applyStimulus(0, 3'd5, 1, 0, 0, 6);
        checkOutput("A edge6 in1", in1, 0);
        checkOutput("A edge6 a_valid", a_valid, 0);
        applyStimulus(0, 3'd5, 1, 0, 0, 1);
        checkOutput("A edge7 in1", in1, 5);
        checkOutput("A edge7 a_valid", a_valid, 1);
        checkOutput("A edge7 in2", in2, 0);
        checkOutput("A edge7 ready", ready, 0);
        applyStimulus(0, 3'd2, 1, 0, 0, 12);
        checkOutput("A held one event", in1, 5);
        applyStimulus(0, 3'd2, 0, 0, 0, 10);
        checkOutput("A release no event", in1, 5);

        // Short glitch must be ignored.
        applyStimulus(0, 3'd6, 1, 0, 0, 3);
        applyStimulus(0, 3'd6, 0, 0, 0, 20);
        checkOutput("glitch in1", in1, 5);
        checkOutput("glitch a_valid", a_valid, 1);

        // Load B=3, then reload A=7.
        applyStimulus(0, 3'd3, 0, 1, 0, 7);
        checkOutput("B in1", in1, 5);
        checkOutput("B in2", in2, 3);
        checkOutput("B ready", ready, 1);
        checkOutput("B sum", in1 + in2, 8);
        applyStimulus(0, 3'd3, 0, 0, 0, 8);
        applyStimulus(0, 3'd7, 1, 0, 0, 7);
        checkOutput("reload in1", in1, 7);
        checkOutput("reload ready", ready, 1);
        applyStimulus(0, 3'd7, 0, 0, 0, 8);

        // Clear and A pressed together: clear wins.
        applyStimulus(0, 3'd7, 1, 0, 1, 7);
        checkOutput("clr in1", in1, 0);
        checkOutput("clr in2", in2, 0);
        checkOutput("clr a_valid", a_valid, 0);
        checkOutput("clr ready", ready, 0);
        applyStimulus(0, 3'd7, 0, 0, 0, 8);

        // Reset mid-debounce discards the partial count.
        applyStimulus(0, 3'd6, 0, 1, 0, 3);
        applyStimulus(1, 3'd6, 0, 1, 0, 1);
        applyStimulus(0, 3'd6, 0, 1, 0, 6);
        checkOutput("rst-mid b_valid early", b_valid, 0);
        checkOutput("rst-mid in2 early", in2, 0);
        applyStimulus(0, 3'd6, 0, 1, 0, 1);
        checkOutput("rst-mid in2", in2, 6);
        checkOutput("rst-mid b_valid", b_valid, 1);
        applyStimulus(0, 3'd6, 0, 0, 0, 8);

        // Simultaneous A and B load the same value.
        applyStimulus(0, 3'd4, 1, 1, 0, 7);
        checkOutput("AB in1", in1, 4);
        checkOutput("AB in2", in2, 4);
        checkOutput("AB ready", ready, 1);
        applyStimulus(0, 3'd4, 0, 0, 0, 8);

        // Random button traffic with short and long holds and rare resets.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] s;
            logic ra, rb, rc, rr;
            s  = 3'($urandom);
            ra = ($urandom_range(0, 2) == 0);
            rb = ($urandom_range(0, 2) == 0);
            rc = ($urandom_range(0, 6) == 0);
            rr = ($urandom_range(0, 40) == 0);
            applyStimulus(rr, s, ra, rb, rc, $urandom_range(1, 10));
        end
        applyStimulus(0, 3'd0, 0, 0, 0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
